// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam int MAX_BPW = 9;

    // Callers zero-extend narrower words; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_BPW-1:0] word, input parity_e mode);
        case (mode)
            PAR_EVEN: return ^word;
            PAR_ODD:  return ~^word;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchroniser that resets to the idle-high line level
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampled UART receiver packing serial words into valid/ready beats
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int      CLOCKS_PER_PULSE = 16,
    parameter int      BITS_PER_WORD    = 8,
    parameter int      W_OUT            = 16,
    parameter parity_e PARITY_MODE      = PAR_EVEN,
    parameter int      STOP_BITS        = 1,
    parameter int      SYNC_STAGES      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W_OUT-1:0] m_data,
    output logic             err_parity,
    output logic             err_frame,
    output logic             err_overrun
);

    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CW        = $clog2(CLOCKS_PER_PULSE);
    localparam int BW        = $clog2(BITS_PER_WORD);
    localparam int WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic rx_s;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rx),
        .q_o(rx_s)
    );

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          c_clocks_q, c_clocks_d;
    logic [BW-1:0]          c_bits_q, c_bits_d;
    logic [WW-1:0]          c_words_q, c_words_d;
    logic [BITS_PER_WORD-1:0] word_q, word_d;
    logic [W_OUT-1:0]       asm_q, asm_d;
    logic [W_OUT-1:0]       m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   err_parity_q, err_parity_d;
    logic                   err_frame_q, err_frame_d;
    logic                   err_overrun_q, err_overrun_d;
    logic [1:0]             hist_q;

    logic bit_done;
    logic vote;
    logic [MAX_BPW-1:0] word_ext;

    // hist_q holds rx_s from the two previous cycles, so at the decision
    // count the vote spans counts CPP-3, CPP-2 and CPP-1.
    assign vote     = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
    assign bit_done = (c_clocks_q == CW'(CLOCKS_PER_PULSE - 1));
    assign word_ext = MAX_BPW'(word_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            c_clocks_q    <= '0;
            c_bits_q      <= '0;
            c_words_q     <= '0;
            word_q        <= '0;
            asm_q         <= '0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            err_parity_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            hist_q        <= '1;
        end else begin
            state_q       <= state_d;
            c_clocks_q    <= c_clocks_d;
            c_bits_q      <= c_bits_d;
            c_words_q     <= c_words_d;
            word_q        <= word_d;
            asm_q         <= asm_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            err_parity_q  <= err_parity_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
            hist_q        <= {hist_q[0], rx_s};
        end
    end

    always_comb begin
        state_d       = state_q;
        c_clocks_d    = c_clocks_q;
        c_bits_d      = c_bits_q;
        c_words_d     = c_words_q;
        word_d        = word_q;
        asm_d         = asm_q;
        m_data_d      = m_data_q;
        m_valid_d     = m_valid_q & ~m_ready;
        err_parity_d  = 1'b0;
        err_frame_d   = 1'b0;
        err_overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    c_clocks_d = '0;
                end
            end

            START: begin
                if (c_clocks_q == CW'(CLOCKS_PER_PULSE / 2 - 1)) begin
                    c_clocks_d = '0;
                    c_bits_d   = '0;
                    state_d    = rx_s ? IDLE : DATA;
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    c_clocks_d = '0;
                    word_d     = {vote, word_q[BITS_PER_WORD-1:1]};
                    if (c_bits_q == BW'(BITS_PER_WORD - 1)) begin
                        c_bits_d = '0;
                        state_d  = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        c_bits_d = c_bits_q + 1'b1;
                    end
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end

            PARITY: begin
                if (bit_done) begin
                    c_clocks_d = '0;
                    if (parity_bit(word_ext, PARITY_MODE) != vote) begin
                        err_parity_d = 1'b1;
                        c_words_d    = '0;
                        state_d      = WAIT_IDLE;
                    end else begin
                        state_d = STOP;
                    end
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    c_clocks_d = '0;
                    if (!vote) begin
                        err_frame_d = 1'b1;
                        c_words_d   = '0;
                        c_bits_d    = '0;
                        state_d     = WAIT_IDLE;
                    end else if (c_bits_q == BW'(STOP_BITS - 1)) begin
                        c_bits_d = '0;
                        state_d  = IDLE;
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            if (c_words_q == WW'(i)) begin
                                asm_d[i*BITS_PER_WORD +: BITS_PER_WORD] = word_q;
                            end
                        end
                        if (c_words_q == WW'(NUM_WORDS - 1)) begin
                            c_words_d = '0;
                            // A beat may replace the held one only if it is leaving this cycle.
                            if (!m_valid_q || m_ready) begin
                                m_data_d  = asm_d;
                                m_valid_d = 1'b1;
                            end else begin
                                err_overrun_d = 1'b1;
                            end
                        end else begin
                            c_words_d = c_words_q + 1'b1;
                        end
                    end else begin
                        c_bits_d = c_bits_q + 1'b1;
                    end
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end

            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;

endmodule
